// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: FSM state, PC increment, default reset vector.
// PC_MISALIGN_TRAP_EN adds the TRAP state.
package fetch_pkg;

  localparam logic [31:0] PC_INC = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD
`ifdef PC_MISALIGN_TRAP_EN
    ,
    TRAP
`endif
  } fetch_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux (jump > branch > sequential) and target alignment check.
// Redirect targets are always word-aligned; misaligned flags dropped low bits.
module pc_next_sel
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        redirect,
  output logic        misaligned
);

  logic [31:0] target;

  assign pc_plus4   = pc + PC_INC;
  assign redirect   = jump | branch_taken;
  assign target     = jump ? jump_target : branch_target;
  assign misaligned = redirect & (|target[1:0]);

  assign next_pc = redirect ? {target[31:2], 2'b00}
                            : pc_plus4;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: PC register, imem request FSM, decode handoff.
// Define PC_MISALIGN_TRAP_EN to trap on misaligned redirect targets.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instr,
  output logic        misalign_err
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic [31:0]  next_pc;
  logic         redirect;
  logic         misaligned;
  logic         trapped;
  logic         fetch_done;
  logic         handoff;

  pc_next_sel u_sel (
    .pc            (pc),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc_plus4      (pc_plus4),
    .next_pc       (next_pc),
    .redirect      (redirect),
    .misaligned    (misaligned)
  );

`ifdef PC_MISALIGN_TRAP_EN
  assign trapped      = (state == TRAP);
  assign misalign_err = trapped;
`else
  logic misalign_unused;
  assign misalign_unused = misaligned;
  assign trapped         = 1'b0;
  assign misalign_err    = 1'b0;
`endif

  assign imem_addr  = pc;
  assign imem_req   = (state == REQ) && !stall;
  assign if_valid   = (state == HOLD);
  assign fetch_done = imem_req && imem_ready;
  assign handoff    = if_valid && if_ready && !stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      if_pc       <= '0;
      if_pc_plus4 <= '0;
      if_instr    <= '0;
    end else if (redirect && !trapped) begin
`ifdef PC_MISALIGN_TRAP_EN
      if (misaligned) begin
        state <= TRAP;
      end else begin
        pc    <= next_pc;
        state <= REQ;
      end
`else
      pc    <= next_pc;
      state <= REQ;
`endif
    end else begin
      unique case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (fetch_done) begin
            if_pc       <= pc;
            if_pc_plus4 <= pc_plus4;
            if_instr    <= imem_rdata;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (handoff) begin
            pc    <= next_pc;
            state <= REQ;
          end
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be asynchronous, active-high reset.
REQ-004 stall  input  1  SHALL, when high, freeze the PC and FSM (redirects excepted).
REQ-005 branch_taken  input  1  SHALL request a redirect to branch_target.
REQ-006 branch_target  input  32  SHALL be the branch destination from the branch-target adder.
REQ-007 jump  input  1  SHALL request a redirect to jump_target.
REQ-008 jump_target  input  32  SHALL be the jump destination.
REQ-009 imem_req  output  1  SHALL be the instruction-memory read request.
REQ-010 imem_addr  output  32  SHALL be the fetch address (equal to the current PC).
REQ-011 imem_ready  input  1  SHALL mark imem_rdata valid; a transfer completes when imem_req and imem_ready are both high.
REQ-012 imem_rdata  input  32  SHALL be the fetched instruction word.
REQ-013 if_valid  output  1  SHALL mark if_pc, if_pc_plus4 and if_instr valid to decode.
REQ-014 if_ready  input  1  SHALL mark decode acceptance; a handoff completes when if_valid and if_ready are both high.
REQ-015 if_pc, if_pc_plus4, if_instr  output  32 each  SHALL be the captured PC, PC+4 and instruction.
REQ-016 misalign_err  output  1  SHALL flag a misaligned redirect (see Configuration).

Function
REQ-017 FSM states SHALL be IDLE, REQ, HOLD and TRAP. Reset enters IDLE; IDLE goes to REQ on the next edge unconditionally.
REQ-018 In REQ, imem_req SHALL be 1. On imem_ready with no redirect, the block captures PC, PC+4 and rdata and goes to HOLD.
REQ-019 In HOLD, if_valid SHALL be 1 and outputs SHALL stay stable until the handoff.
REQ-020 On handoff with stall low, PC SHALL become PC+4 and the FSM goes to REQ on the same edge.
REQ-021 With stall high, HOLD SHALL be held even if if_ready is high, and REQ SHALL deassert imem_req.
REQ-022 Next-PC priority SHALL be jump > branch_taken > sequential.
REQ-023 A redirect in any state other than TRAP SHALL load the target into PC, clear if_valid, and enter REQ on the next edge.
REQ-024 If a redirect coincides with imem_ready, the returned word SHALL be discarded.
REQ-025 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000) with no flag.
REQ-026 Fetch latency SHALL be 1 cycle from imem_ready to if_valid, and a minimum of 2 cycles per instruction with zero-wait memory.

Reset
REQ-027 Asserting reset SHALL immediately set PC=RESET_PC, state=IDLE, and drive imem_req=0, if_valid=0, misalign_err=0, and if_pc/if_pc_plus4/if_instr=0.
REQ-028 Reset mid-transaction SHALL abandon any outstanding request; a late imem_ready after reset SHALL be ignored in IDLE.

Configuration
REQ-029 Macro PC_MISALIGN_TRAP_EN defined: a redirect target with bits[1:0]!=0 SHALL enter TRAP. TRAP sets misalign_err=1 (sticky), holds imem_req=0 and if_valid=0, and exits only on reset.
REQ-030 Macro undefined: target bits[1:0] SHALL be forced to 0, misalign_err SHALL be tied 0, and TRAP SHALL not exist.

Structure
REQ-031 Package fetch_pkg SHALL hold the FSM state enum, the PC_INC=4 constant, and the default RESET_PC.
REQ-032 Sub-module pc_next_sel SHALL implement the combinational next-PC priority mux and the alignment check.

Verification
REQ-033 Reset release, imem_ready always 1, if_ready always 1 -> imem_addr sequence 0x0, 0x4, 0x8; if_pc_plus4=0x4 for the first instruction.
REQ-034 In HOLD with if_pc=0x10, stall=1 and if_ready=1 for 3 cycles -> outputs unchanged and no new imem_req; stall=0 -> next imem_addr=0x14.
REQ-035 jump=1 (target 0x100) and branch_taken=1 (target 0x200) in the same cycle as imem_ready -> word dropped, next imem_addr=0x100.
REQ-036 Redirect to 0xFFFF_FFFC, then sequential fetch -> following imem_addr=0x0.
REQ-037 Assert reset while in REQ, then pulse imem_ready -> if_valid stays 0 and the first request after reset is to RESET_PC.
REQ-038 Branch to 0x102: with PC_MISALIGN_TRAP_EN -> misalign_err=1 and imem_req=0 until reset; without it -> imem_addr=0x100.
